// File: rtl/rv32_ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply or restoring divide, one bit per cycle; stalls ID/EX through busy.
`timescale 1ns/1ps
module rv32_ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        m_valid,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic              valid_q, valid_d;

    // Operand decode for the instruction waiting in ID/EX
    logic            is_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2;

    always_comb begin
        is_div   = funct3[2];
        sgn1     = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
        sgn2     = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
        neg1     = sgn1 & rs1_data[XLEN-1];
        neg2     = sgn2 & rs2_data[XLEN-1];
        mag1     = neg1 ? (~rs1_data + 32'd1) : rs1_data;
        mag2     = neg2 ? (~rs2_data + 32'd1) : rs2_data;
        div_zero = is_div & (rs2_data == 32'd0);
        div_ovf  = is_div & ~funct3[0] & (rs1_data == 32'h8000_0000) & (rs2_data == 32'hFFFF_FFFF);
    end

    // One iteration of each algorithm plus the final sign fix-up
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_step, div_step, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, res_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_step  = {mul_sum, acc_q[31:1]};
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = ~div_diff[XLEN];
        div_step  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};
        prod_fix  = neg_q ? (~mul_step + 64'd1) : mul_step;
        quo_fix   = neg_q ? (~div_step[31:0] + 32'd1) : div_step[31:0];
        rem_fix   = rem_neg_q ? (~div_step[63:32] + 32'd1) : div_step[63:32];
        if (f3_q[2])
            res_fix = f3_q[1] ? rem_fix : quo_fix;
        else
            res_fix = (f3_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        valid_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (m_valid) begin
                    f3_d      = funct3;
                    rd_d      = rd_in;
                    cnt_d     = '0;
                    neg_d     = neg1 ^ neg2;
                    rem_neg_d = neg1;
                    if (div_zero | div_ovf) begin
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        rd_out_d = rd_in;
                        if (div_zero)
                            result_d = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
                        else
                            result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state_d = S_RUN;
                        opb_d   = is_div ? mag2 : mag1;
                        acc_d   = {32'd0, (is_div ? mag1 : mag2)};
                    end
                end
            end
            S_RUN: begin
                acc_d = f3_q[2] ? div_step : mul_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    result_d = res_fix;
                    rd_out_d = rd_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A flush abandons the operation and leaves the last result untouched
        if (flush) begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
            valid_q   <= valid_d;
        end
    end

    assign busy         = m_valid & ~flush & ~rst & (state_q != S_DONE);
    assign result_valid = valid_q;
    assign result       = result_q;
    assign rd_out       = rd_out_q;

endmodule

// File: tb/tb_rv32_ex_muldiv.sv
// Bench for rv32_ex_muldiv: directed RV32M vectors, scoreboard checked by a result monitor.
`timescale 1ns/1ps
module tb_rv32_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst, flush, m_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  rd_in;
    logic        busy, result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    rv32_ex_muldiv dut (
        .clk(clk), .rst(rst), .flush(flush), .m_valid(m_valid), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .busy(busy), .result_valid(result_valid), .result(result), .rd_out(rd_out)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   valid_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (result_valid) begin
            exp_t e;
            valid_cyc = cyc;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: result 0x%08h rd %0d with nothing outstanding", result, rd_out);
            end else begin
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("rd_out", 32'(rd_out), 32'(e.rd));
            end
        end
    end

    // Present one instruction at posedge+1 (its cycle 0) and hold it while busy
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input bit special);
        int nbusy;
        exp_t e;
        m_valid  = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        e.rd     = rd;
        e.res    = exp;
        sb_q.push_back(e);
        nbusy = 0;
        @(negedge clk);
        while (busy && nbusy < 40) begin
            nbusy++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 32'(nbusy), special ? 32'd1 : 32'd33);
        check({name, "_valid_cycle"}, 32'(result_valid), 32'd1);
        @(posedge clk);
        #1;
        m_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v1;
        rst = 1'b1; flush = 1'b0; m_valid = 1'b0;
        funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd", 32'(rd_out), 32'd0);
        @(posedge clk);
        #1;

        run_op("mul_neg",   3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1'b0);
        run_op("mulh",      3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 1'b0);
        run_op("mulhu",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'd2,         5'd4,  32'hFFFF_FFFF, 1'b0);
        run_op("divu",      3'b101, 32'd100,       32'd7,         5'd5,  32'd14,        1'b0);
        run_op("remu",      3'b111, 32'd100,       32'd7,         5'd6,  32'd2,         1'b0);
        run_op("div_neg",   3'b100, 32'hFFFF_FF9C, 32'd7,         5'd7,  32'hFFFF_FFF2, 1'b0);
        run_op("rem_neg",   3'b110, 32'hFFFF_FF9C, 32'd7,         5'd8,  32'hFFFF_FFFE, 1'b0);
        run_op("div_negb",  3'b100, 32'd7,         32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_negb",  3'b110, 32'd7,         32'hFFFF_FFFE, 5'd14, 32'd1,         1'b0);
        run_op("divu_max",  3'b101, 32'hFFFF_FFFF, 32'd1,         5'd15, 32'hFFFF_FFFF, 1'b0);
        run_op("div_zero",  3'b100, 32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 1'b1);
        run_op("rem_zero",  3'b110, 32'd5,         32'd0,         5'd17, 32'd5,         1'b1);
        run_op("divu_zero", 3'b101, 32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1'b1);
        run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         1'b1);

        // Flush a DIVU in its cycle 10; the following MUL must start cleanly from IDLE
        m_valid = 1'b1; funct3 = 3'b101; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd9;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_valid", 32'(result_valid), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd10, 32'd12, 1'b0);

        // Reset in cycle 20 of a MUL discards everything
        m_valid = 1'b1; funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9; rd_in = 5'd11;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_busy_after", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(result_valid), 32'd0);
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_rd", 32'(rd_out), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;

        run_op("b2b_first",  3'b000, 32'd6,         32'd7,         5'd12, 32'd42,        1'b0);
        v1 = valid_cyc;
        run_op("b2b_second", 3'b000, 32'h0000_FFFF, 32'h0001_0001, 5'd21, 32'hFFFF_FFFF, 1'b0);
        check("b2b_spacing", 32'(valid_cyc - v1), 32'd34);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
